// File: rtl/inv_shift_rows_stream.sv
// inv_shift_rows_stream
//   Column-serial InvShiftRows stage for the decryption datapath. A 4x4 state
//   arrives one column per beat, is collected in one of two ping-pong buffers,
//   and leaves column-serially with out[r][c] = in[r][(c-r) mod 4]. While one
//   buffer drains, the other fills, so both sides can stream 1 column/cycle.
//
// Parameters
//   d       shares per state element (masking order + 1)
//   BYTE_W  bits per share; element width EW = d*BYTE_W
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input column valid
//   in_ready   input column accepted when in_valid & in_ready
//   in_col     input column, row r at [r*EW +: EW]; beats arrive c=0..3
//   in_inv     (ISR_BIDIR_EN only) 1 = inverse shift, 0 = forward shift,
//              sampled with the first beat of each state
//   out_valid  output column valid
//   out_ready  output column consumed when out_valid & out_ready
//   out_col    shifted output column, same row packing; zero when idle
//
// Configuration macro
//   ISR_BIDIR_EN  adds the in_inv port and per-buffer shift direction
module inv_shift_rows_stream #(
  parameter int d      = 1,
  parameter int BYTE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*d*BYTE_W-1:0] in_col,
`ifdef ISR_BIDIR_EN
  input  logic                  in_inv,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*d*BYTE_W-1:0] out_col
);

  localparam int EW = d * BYTE_W;

  typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} buf_state_e;

  buf_state_e    state_q [2];
  buf_state_e    state_d [2];
  logic          wsel;
  logic          rsel;
  logic [1:0]    wcnt;
  logic [1:0]    rcnt;
  logic [EW-1:0] mem [2][4][4];
  logic          wr_fire;
  logic          rd_fire;
`ifdef ISR_BIDIR_EN
  logic [1:0]    inv_q;
`endif

  // The write side may only land in a buffer that is still collecting, and the
  // read side may only present a buffer holding a complete state. Because
  // every state passes through the same EMPTY->FILL->FULL->DRAIN order and
  // wsel/rsel toggle in step, the two sides can never touch the same buffer.
  assign in_ready  = (state_q[wsel] == EMPTY) || (state_q[wsel] == FILL);
  assign out_valid = (state_q[rsel] == FULL)  || (state_q[rsel] == DRAIN);
  assign wr_fire   = in_valid  && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // Next-state logic for both buffer FSMs. A buffer is advanced by the write
  // side only while it is the write target, and by the read side only while
  // it is the read target; the last beat on either side closes the phase.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      if (wr_fire && (wsel == 1'(b))) begin
        state_d[b] = (wcnt == 2'd3) ? FULL : FILL;
      end
      if (rd_fire && (rsel == 1'(b))) begin
        state_d[b] = (rcnt == 2'd3) ? EMPTY : DRAIN;
      end
    end
  end

  // Buffer FSM state registers; reset discards any partially collected state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
    end
  end

  // Column counters and buffer selectors. Counters are 2 bits so they wrap
  // to 0 on their own after the 4th beat; the selector flips on that beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsel <= 1'b0;
      rsel <= 1'b0;
      wcnt <= 2'd0;
      rcnt <= 2'd0;
    end else begin
      if (wr_fire) begin
        wcnt <= wcnt + 2'd1;
        if (wcnt == 2'd3) begin
          wsel <= ~wsel;
        end
      end
      if (rd_fire) begin
        rcnt <= rcnt + 2'd1;
        if (rcnt == 2'd3) begin
          rsel <= ~rsel;
        end
      end
    end
  end

  // State storage. Each accepted beat lands in column wcnt of the buffer
  // being filled. Contents are cleared on reset so nothing from an aborted
  // state can ever resurface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            mem[b][r][c] <= '0;
          end
        end
      end
    end else if (wr_fire) begin
      for (int r = 0; r < 4; r++) begin
        mem[wsel][r][wcnt] <= in_col[r*EW +: EW];
      end
    end
  end

`ifdef ISR_BIDIR_EN
  // Shift direction is latched with the first beat of a state and travels
  // with that buffer, so later beats' in_inv values have no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 2'b00;
    end else if (wr_fire && (wcnt == 2'd0)) begin
      inv_q[wsel] <= in_inv;
    end
  end
`endif

  // Output column mux. Row r picks column (rcnt - r) mod 4 of the buffer being
  // drained; the 2-bit index arithmetic provides the wrap. Each element is
  // moved whole, so shares are permuted together and never combined. The
  // column is forced to zero while idle so stale shares are not exposed.
  always_comb begin
    out_col = '0;
    if (out_valid) begin
      for (int r = 0; r < 4; r++) begin
`ifdef ISR_BIDIR_EN
        if (inv_q[rsel]) begin
          out_col[r*EW +: EW] = mem[rsel][r][rcnt - 2'(r)];
        end else begin
          out_col[r*EW +: EW] = mem[rsel][r][rcnt + 2'(r)];
        end
`else
        out_col[r*EW +: EW] = mem[rsel][r][rcnt - 2'(r)];
`endif
      end
    end
  end

endmodule
